// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: forwarding selects, load-use and branch handling, and data-memory wait tracking.
// Optional build macro HAZARD_PERF_EN adds the Stall_Cnt/Flush_Cnt performance counters.
module hazard_ctrl #(
  parameter int WAIT_TIMEOUT = 255,
  parameter int CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic [4:0]       Rd_M,
  input  logic [4:0]       Rd_W,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic [1:0]       ResultSrc_E,
  input  logic             PcSrc_E,
  input  logic             MemReq_M,
  input  logic             MemReady,
  output logic [1:0]       Forward_AE,
  output logic [1:0]       Forward_BE,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Stall_E,
  output logic             Stall_M,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic             Flush_W,
  output logic [CNT_W-1:0] Wait_Cnt,
  output logic             Mem_Err,
  output logic [1:0]       State_Dbg
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      Stall_Cnt,
  output logic [31:0]      Flush_Cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(WAIT_TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] waitCnt;
  logic [CNT_W-1:0] nextCnt;
  logic             memErr;
  logic             loadStall;
  logic             memStall;
  logic             timeoutHit;

  // MEM -> WB priority; register 0 is hardwired and never forwards.
  function automatic logic [1:0] fwdSel(
    input logic [4:0] rs,
    input logic [4:0] rdM,
    input logic       wrM,
    input logic [4:0] rdW,
    input logic       wrW
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (wrM && (rdM != 5'd0) && (rdM == rs)) begin
      sel = 2'b10;
    end else if (wrW && (rdW != 5'd0) && (rdW == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign Forward_AE = fwdSel(Rs1_E, Rd_M, RegWrite_M, Rd_W, RegWrite_W);
  assign Forward_BE = fwdSel(Rs2_E, Rd_M, RegWrite_M, Rd_W, RegWrite_W);

  assign loadStall = (ResultSrc_E == 2'b01) && (Rd_E != 5'd0) &&
                     ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

  // MemReq_M/MemReady handshake: an access completes in the cycle where both are
  // high; every cycle with MemReq_M high and MemReady low is a wait cycle.
  assign memStall = MemReq_M && !MemReady;

  always_comb begin
    Stall_F = 1'b0;
    Stall_D = 1'b0;
    Stall_E = 1'b0;
    Stall_M = 1'b0;
    Flush_D = 1'b0;
    Flush_E = 1'b0;
    Flush_W = 1'b0;
    if (memStall) begin
      // Whole front end freezes; WB gets a bubble so nothing retires twice.
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Stall_E = 1'b1;
      Stall_M = 1'b1;
      Flush_W = 1'b1;
    end else if (PcSrc_E) begin
      Flush_D = 1'b1;
      Flush_E = 1'b1;
    end else if (loadStall) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Flush_E = 1'b1;
    end
  end

  assign nextCnt    = (waitCnt == {CNT_W{1'b1}}) ? waitCnt : waitCnt + ONE_C;
  assign timeoutHit = (nextCnt >= TIMEOUT_C);

  // Mem_Err rises on the same edge that Wait_Cnt reaches WAIT_TIMEOUT.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= RUN;
      waitCnt <= '0;
      memErr  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (memStall) begin
            waitCnt <= ONE_C;
            if (TIMEOUT_C <= ONE_C) begin
              state  <= ERR;
              memErr <= 1'b1;
            end else begin
              state <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (!memStall) begin
            state   <= RUN;
            waitCnt <= '0;
          end else begin
            waitCnt <= nextCnt;
            if (timeoutHit) begin
              state  <= ERR;
              memErr <= 1'b1;
            end
          end
        end
        ERR: begin
          if (!memStall) begin
            state   <= RUN;
            waitCnt <= '0;
          end else begin
            waitCnt <= nextCnt;
          end
        end
        default: begin
          state   <= RUN;
          waitCnt <= '0;
        end
      endcase
    end
  end

  assign Wait_Cnt  = waitCnt;
  assign Mem_Err   = memErr;
  assign State_Dbg = state;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Stall_Cnt <= 32'd0;
      Flush_Cnt <= 32'd0;
    end else begin
      if (Stall_F) begin
        Stall_Cnt <= Stall_Cnt + 32'd1;
      end
      if (Flush_E) begin
        Flush_Cnt <= Flush_Cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table for the combinational controls, hand sequences for
// memory waits, timeout, saturation and asynchronous reset, plus random forwarding checks.
module tb_hazard_ctrl;
  localparam int W = 32;
  localparam int CW = 3;

  logic          Clk;
  logic          Reset;
  logic [4:0]    Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic          RegWrite_M, RegWrite_W;
  logic [1:0]    ResultSrc_E;
  logic          PcSrc_E, MemReq_M, MemReady;
  logic [1:0]    Forward_AE, Forward_BE;
  logic          Stall_F, Stall_D, Stall_E, Stall_M;
  logic          Flush_D, Flush_E, Flush_W;
  logic [CW-1:0] Wait_Cnt;
  logic          Mem_Err;
  logic [1:0]    State_Dbg;
`ifdef HAZARD_PERF_EN
  logic [31:0]   Stall_Cnt, Flush_Cnt;
`endif

  logic [10:0]   outs;
  assign outs = {Forward_AE, Forward_BE, Stall_F, Stall_D, Stall_E, Stall_M,
                 Flush_D, Flush_E, Flush_W};

  hazard_ctrl #(.WAIT_TIMEOUT(4), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
    .Rd_M(Rd_M), .Rd_W(Rd_W), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .ResultSrc_E(ResultSrc_E), .PcSrc_E(PcSrc_E), .MemReq_M(MemReq_M), .MemReady(MemReady),
    .Forward_AE(Forward_AE), .Forward_BE(Forward_BE),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
    .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_W(Flush_W),
    .Wait_Cnt(Wait_Cnt), .Mem_Err(Mem_Err), .State_Dbg(State_Dbg)
`ifdef HAZARD_PERF_EN
    , .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
`endif
  );

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    string      name;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       rwM, rwW;
    logic [1:0] rsrc;
    logic       pc, req, rdy;
    logic [10:0] exp;
  } vec_t;

  vec_t           vq[$];
  logic [W-1:0]   exp_q[$];
  int             n_tests = 0;
  int             n_fail  = 0;

  // scoreboard
  task automatic push_exp(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_cmp(input string name, input logic [W-1:0] act);
    logic [W-1:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected value queued, got %0h", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h", name, act, e);
      end
    end
  endtask

  // drivers
  task automatic clear_inputs();
    Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; Rd_E = 0; Rd_M = 0; Rd_W = 0;
    RegWrite_M = 0; RegWrite_W = 0; ResultSrc_E = 2'b00;
    PcSrc_E = 0; MemReq_M = 0; MemReady = 0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic add_vec(input string name,
                         input logic [4:0] rs1D, input logic [4:0] rs2D,
                         input logic [4:0] rs1E, input logic [4:0] rs2E,
                         input logic [4:0] rdE, input logic [4:0] rdM, input logic [4:0] rdW,
                         input logic rwM, input logic rwW, input logic [1:0] rsrc,
                         input logic pc, input logic req, input logic rdy,
                         input logic [10:0] exp);
    vec_t v;
    v.name = name; v.rs1D = rs1D; v.rs2D = rs2D; v.rs1E = rs1E; v.rs2E = rs2E;
    v.rdE = rdE; v.rdM = rdM; v.rdW = rdW; v.rwM = rwM; v.rwW = rwW; v.rsrc = rsrc;
    v.pc = pc; v.req = req; v.rdy = rdy; v.exp = exp;
    vq.push_back(v);
  endtask

  task automatic drive_vec(input vec_t v);
    Rs1_D = v.rs1D; Rs2_D = v.rs2D; Rs1_E = v.rs1E; Rs2_E = v.rs2E;
    Rd_E = v.rdE; Rd_M = v.rdM; Rd_W = v.rdW;
    RegWrite_M = v.rwM; RegWrite_W = v.rwW; ResultSrc_E = v.rsrc;
    PcSrc_E = v.pc; MemReq_M = v.req; MemReady = v.rdy;
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input logic wM, input logic [4:0] dM,
                                         input logic wW, input logic [4:0] dW);
    if (rs == 0) return 2'b00;
    if (wM && dM == rs) return 2'b10;
    if (wW && dW == rs) return 2'b01;
    return 2'b00;
  endfunction

  initial begin
    // outs order: {Fa, Fb, SF, SD, SE, SM, FD, FE, FW}
    add_vec("fwd_a_mem",    0, 0, 5, 0, 0, 5, 5, 1, 1, 2'b00, 0, 0, 0, 11'b10_00_0000_000);
    add_vec("fwd_a_wb",     0, 0, 5, 0, 0, 0, 5, 1, 1, 2'b00, 0, 0, 0, 11'b01_00_0000_000);
    add_vec("fwd_a_x0",     0, 0, 0, 0, 0, 0, 5, 1, 1, 2'b00, 0, 0, 0, 11'b00_00_0000_000);
    add_vec("fwd_b_mem",    0, 0, 3, 3, 0, 3, 0, 1, 0, 2'b00, 0, 0, 0, 11'b10_10_0000_000);
    add_vec("fwd_b_wb",     0, 0, 0, 3, 0, 3, 3, 0, 1, 2'b00, 0, 0, 0, 11'b00_01_0000_000);
    add_vec("fwd_b_nowr",   0, 0, 0, 3, 0, 0, 3, 0, 0, 2'b00, 0, 0, 0, 11'b00_00_0000_000);
    add_vec("fwd_b_prio",   0, 0, 0, 6, 0, 6, 6, 1, 1, 2'b00, 0, 0, 0, 11'b00_10_0000_000);
    add_vec("load_rs2",     0, 7, 0, 0, 7, 0, 0, 0, 0, 2'b01, 0, 0, 0, 11'b00_00_1100_010);
    add_vec("load_rd0",     0, 7, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 11'b00_00_0000_000);
    add_vec("nonload",      7, 0, 0, 0, 7, 0, 0, 0, 0, 2'b10, 0, 0, 0, 11'b00_00_0000_000);
    add_vec("load_rs1",     9, 0, 0, 0, 9, 0, 0, 0, 0, 2'b01, 0, 0, 0, 11'b00_00_1100_010);
    add_vec("pc_over_load", 9, 0, 0, 0, 9, 0, 0, 0, 0, 2'b01, 1, 0, 0, 11'b00_00_0000_110);
    add_vec("pc_only",      0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 11'b00_00_0000_110);
    add_vec("mem_over_all", 9, 0, 0, 0, 9, 0, 0, 0, 0, 2'b01, 1, 1, 0, 11'b00_00_1111_001);
    add_vec("ready_pc",     0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 1, 11'b00_00_0000_110);
    add_vec("ready_load",   9, 0, 0, 0, 9, 0, 0, 0, 0, 2'b01, 0, 1, 1, 11'b00_00_1100_010);
    add_vec("noreq_load",   9, 0, 0, 0, 9, 0, 0, 0, 0, 2'b01, 0, 0, 1, 11'b00_00_1100_010);

    // reset state
    clear_inputs();
    Reset = 1'b1;
    #12;
    push_exp(0); pop_cmp("rst_wait_cnt", W'(Wait_Cnt));
    push_exp(0); pop_cmp("rst_mem_err", W'(Mem_Err));
    push_exp(0); pop_cmp("rst_state", W'(State_Dbg));
    push_exp(0); pop_cmp("rst_outs", W'(outs));
    Reset = 1'b0;

    // table vectors
    foreach (vq[i]) begin
      step();
      drive_vec(vq[i]);
      push_exp(W'(vq[i].exp));
      @(negedge Clk);
      pop_cmp(vq[i].name, W'(outs));
    end

    // three-cycle wait with a taken branch held in EX
    step(); clear_inputs();
    step();
    MemReq_M = 1; MemReady = 0; PcSrc_E = 1;
    for (int i = 1; i <= 3; i++) begin
      push_exp(W'(11'b00_00_1111_001));
      @(negedge Clk); pop_cmp("wait_outs", W'(outs));
      step();
      push_exp(W'(i)); pop_cmp("wait_cnt", W'(Wait_Cnt));
      push_exp(1);     pop_cmp("wait_state", W'(State_Dbg));
    end
    MemReady = 1;
    push_exp(W'(11'b00_00_0000_110));
    @(negedge Clk); pop_cmp("release_outs", W'(outs));
    step();
    push_exp(0); pop_cmp("release_cnt", W'(Wait_Cnt));
    push_exp(0); pop_cmp("release_state", W'(State_Dbg));
    push_exp(0); pop_cmp("release_err", W'(Mem_Err));

    // timeout at 4 and saturation at 7
    clear_inputs();
    step();
    MemReq_M = 1; MemReady = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      push_exp(W'((k > 7) ? 7 : k)); pop_cmp("to_cnt", W'(Wait_Cnt));
      push_exp(W'(k >= 4));          pop_cmp("to_err", W'(Mem_Err));
      push_exp(W'((k < 4) ? 1 : 2)); pop_cmp("to_state", W'(State_Dbg));
    end
    MemReq_M = 0;
    step();
    push_exp(0); pop_cmp("to_rel_cnt", W'(Wait_Cnt));
    push_exp(0); pop_cmp("to_rel_state", W'(State_Dbg));
    push_exp(1); pop_cmp("to_rel_err", W'(Mem_Err));
    step();
    push_exp(1); pop_cmp("to_sticky_err", W'(Mem_Err));

    // asynchronous reset in cycle 2 of a wait, with Mem_Err still set
    MemReq_M = 1; MemReady = 0;
    step();
    push_exp(1); pop_cmp("ar_pre_cnt", W'(Wait_Cnt));
    #2;
    Reset = 1'b1;
    #1;
    push_exp(0); pop_cmp("ar_cnt", W'(Wait_Cnt));
    push_exp(0); pop_cmp("ar_err", W'(Mem_Err));
    push_exp(0); pop_cmp("ar_state", W'(State_Dbg));
    push_exp(W'(11'b00_00_1111_001)); pop_cmp("ar_outs", W'(outs));
`ifdef HAZARD_PERF_EN
    push_exp(0); pop_cmp("ar_stall_cnt", Stall_Cnt);
    push_exp(0); pop_cmp("ar_flush_cnt", Flush_Cnt);
`endif
    #1;
    Reset = 1'b0;
    MemReq_M = 0;
    step();
    push_exp(0); pop_cmp("ar_post_cnt", W'(Wait_Cnt));
    push_exp(0); pop_cmp("ar_post_state", W'(State_Dbg));

    // random forwarding over a small register range to force matches
    for (int i = 0; i < 16; i++) begin
      step();
      clear_inputs();
      Rd_M = 5'($urandom_range(0, 3)); Rd_W = 5'($urandom_range(0, 3));
      Rs1_E = 5'($urandom_range(0, 3)); Rs2_E = 5'($urandom_range(0, 3));
      RegWrite_M = 1'($urandom_range(0, 1)); RegWrite_W = 1'($urandom_range(0, 1));
      push_exp(W'({fwd_ref(Rs1_E, RegWrite_M, Rd_M, RegWrite_W, Rd_W),
                   fwd_ref(Rs2_E, RegWrite_M, Rd_M, RegWrite_W, Rd_W), 7'b0}));
      @(negedge Clk);
      pop_cmp("rand_fwd", W'(outs));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
